// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids and the
// latched memory command.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LD   = 1'b1;

   // Command fields hold addresses/data up to this width.
   localparam int unsigned CmdAddrW = 32;
   localparam int unsigned CmdDataW = 32;

   typedef struct packed {
      logic                we;
      logic [CmdAddrW-1:0] addr;
      logic [CmdDataW-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker: round-robin on ties when RR_EN is set, otherwise the
// core port always wins. The last-grant pointer starts on the loader port.
module rr_arb2
   import dmem_arb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic       gnt_valid_o,
   output logic       gnt_id_o
);

   logic last_q, last_d;

   always_comb begin
      gnt_valid_o = |req_i;
      unique case (req_i)
         2'b01:   gnt_id_o = PORT_CORE;
         2'b10:   gnt_id_o = PORT_LD;
         2'b11:   gnt_id_o = RR_EN ? ~last_q : PORT_CORE;
         default: gnt_id_o = PORT_CORE;
      endcase
      last_d = take_i ? gnt_id_o : last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= PORT_LD;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core and loader accesses onto a single-port synchronous data
// memory: IDLE latches the winner's command, ISSUE strobes memory, RESP acks.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_ack,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_e            state_q, state_d;
   cmd_t              cmd_q, cmd_d;
   logic              gid_q, gid_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic              core_ack_q, core_ack_d;
   logic              ld_ack_q, ld_ack_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] core_rdata_q, ld_rdata_q;
   logic              arb_valid, arb_id, arb_take;
   cmd_t              core_cmd, ld_cmd;

   assign arb_take = (state_q == StIdle) && arb_valid;

   rr_arb2 #(
      .RR_EN(RR_EN)
   ) u_rr_arb2 (
      .clk        (clk),
      .rst        (rst),
      .req_i      ({ld_req, core_req}),
      .take_i     (arb_take),
      .gnt_valid_o(arb_valid),
      .gnt_id_o   (arb_id)
   );

   always_comb begin
      core_cmd = '{we: core_we, addr: CmdAddrW'(core_addr), wdata: CmdDataW'(core_wdata)};
      ld_cmd   = '{we: ld_we, addr: CmdAddrW'(ld_addr), wdata: CmdDataW'(ld_wdata)};
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      gid_d      = gid_q;
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      core_ack_d = 1'b0;
      ld_ack_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               cmd_d    = (arb_id == PORT_LD) ? ld_cmd : core_cmd;
               gid_d    = arb_id;
               mem_en_d = 1'b1;
               mem_we_d = cmd_d.we;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            core_ack_d = (gid_q == PORT_CORE);
            ld_ack_d   = (gid_q == PORT_LD);
            state_d    = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   // Memory data arrives in the ack cycle, so loads bypass it straight out and
   // the holding register keeps the value until the next load on that port.
   always_comb begin
      core_rdata = (core_ack_q && !cmd_q.we) ? mem_rdata : core_rdata_q;
      ld_rdata   = (ld_ack_q && !cmd_q.we) ? mem_rdata : ld_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cmd_q        <= '0;
         gid_q        <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         core_ack_q   <= 1'b0;
         ld_ack_q     <= 1'b0;
         busy_q       <= 1'b0;
         core_rdata_q <= '0;
         ld_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         gid_q        <= gid_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         core_ack_q   <= core_ack_d;
         ld_ack_q     <= ld_ack_d;
         busy_q       <= busy_d;
         core_rdata_q <= core_rdata;
         ld_rdata_q   <= ld_rdata;
      end
   end

   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = ADDR_W'(cmd_q.addr);
   assign mem_wdata  = DATA_W'(cmd_q.wdata);
   assign core_ack   = core_ack_q;
   assign ld_ack     = ld_ack_q;
   assign busy       = busy_q;
   assign core_stall = core_req & ~core_ack_q;

endmodule
